program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 194 +++++++++++++++++++
 tb/tb_program_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream boot loader: header N, then N big-endian 16-bit words written to instruction memory.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load_Start,
  input  logic              In_Valid,
  input  logic [7:0]        In_Data,
  output logic              In_Ready,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_Wdata,
  output logic [7:0]        Word_Count,
  output logic              Load_Done,
  output logic              Load_Error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] BASE_S = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [7:0]          count_q, count_d;
  logic [7:0]          n_q, n_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          sum_chk_s;
`endif

  assign accept_s = In_Valid & ready_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    n_d     = n_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    sum_chk_s = sum_q + In_Data;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (Load_Start) begin
          state_d = HEADER;
          count_d = 8'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      HEADER: begin
        if (accept_s) begin
          n_d     = In_Data;
          state_d = (In_Data == 8'd0) ? ERROR : HIGH;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_chk_s;
`endif
        end else begin
          state_d = HEADER;
        end
      end
      HIGH: begin
        if (accept_s) begin
          wdata_d[15:8] = In_Data;
          state_d       = LOW;
`ifdef LOADER_CHECKSUM_EN
          sum_d         = sum_chk_s;
`endif
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (accept_s) begin
          wdata_d[7:0] = In_Data;
          // Address is fixed here so it is already stable for the whole write cycle
          addr_d       = BASE_S + ADDR_W'(count_q);
          state_d      = WRITE;
`ifdef LOADER_CHECKSUM_EN
          sum_d        = sum_chk_s;
`endif
        end else begin
          state_d = LOW;
        end
      end
      WRITE: begin
        count_d = count_q + 8'd1;
        if (count_d < n_q) begin
          state_d = HIGH;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept_s) begin
          state_d = (sum_chk_s == 8'd0) ? DONE : ERROR;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == HEADER) || (state_d == HIGH) || (state_d == LOW)
`ifdef LOADER_CHECKSUM_EN
              || (state_d == CHECK)
`endif
              ;
    we_d   = (state_d == WRITE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERROR);
  end

  // State and datapath registers; reset abandons any partly assembled word
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      n_q     <= 8'd0;
      wdata_q <= 16'd0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign In_Ready   = ready_q;
  assign Mem_We     = we_q;
  assign Mem_Addr   = addr_q;
  assign Mem_Wdata  = wdata_q;
  assign Word_Count = count_q;
  assign Load_Done  = done_q;
  assign Load_Error = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (BASE_ADDR 0 and 254) share one byte stream.
module tb_program_loader;

  logic        Clock;
  logic        Reset;
  logic        Load_Start;
  logic        In_Valid;
  logic [7:0]  In_Data;

  logic        rdy0, we0, done0, err0;
  logic [7:0]  addr0, wc0;
  logic [15:0] wd0;
  logic        rdy1, we1, done1, err1;
  logic [7:0]  addr1, wc1;
  logic [15:0] wd1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  la0 [0:63];
  logic [15:0] ld0 [0:63];
  logic [7:0]  la1 [0:63];
  int nw0 = 0;
  int nw1 = 0;
  int pulses0 = 0;
  logic we0_prev = 1'b0;

  program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Load_Start(Load_Start),
    .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(rdy0),
    .Mem_We(we0), .Mem_Addr(addr0), .Mem_Wdata(wd0),
    .Word_Count(wc0), .Load_Done(done0), .Load_Error(err0)
  );

  program_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
    .Clock(Clock), .Reset(Reset), .Load_Start(Load_Start),
    .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(rdy1),
    .Mem_We(we1), .Mem_Addr(addr1), .Mem_Wdata(wd1),
    .Word_Count(wc1), .Load_Done(done1), .Load_Error(err1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory-write log, taken on the falling edge
  always @(negedge Clock) begin
    if (we0 === 1'b1) begin
      la0[nw0[5:0]] = addr0;
      ld0[nw0[5:0]] = wd0;
      nw0 = nw0 + 1;
      if (we0_prev !== 1'b1) pulses0 = pulses0 + 1;
    end
    if (we1 === 1'b1) begin
      la1[nw1[5:0]] = addr1;
      nw1 = nw1 + 1;
    end
    we0_prev = we0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    In_Valid = 1'b1;
    In_Data  = b;
    while (rdy0 !== 1'b1 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    chk("byte_accept", {31'd0, rdy0}, 32'd1);
    @(negedge Clock);
    In_Valid = 1'b0;
  endtask

  task automatic start_load();
    Load_Start = 1'b1;
    @(negedge Clock);
    Load_Start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done0 !== 1'b1 && err0 !== 1'b1 && n < 100) begin
      @(negedge Clock);
      n++;
    end
  endtask

  int s0, s1, p0;

  initial begin
    Reset = 1'b1;
    Load_Start = 1'b0;
    In_Valid = 1'b0;
    In_Data = 8'h00;
    #1;
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_we",    {31'd0, we0}, 32'd0);
    chk("rst_addr",  {24'd0, addr0}, 32'd0);
    chk("rst_wdata", {16'd0, wd0}, 32'd0);
    chk("rst_count", {24'd0, wc0}, 32'd0);
    chk("rst_done",  {31'd0, done0}, 32'd0);
    chk("rst_err",   {31'd0, err0}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_ready", {31'd0, rdy0}, 32'd0);

    // Three-word load
    s0 = nw0; s1 = nw1; p0 = pulses0;
    start_load();
    send_byte(8'h03);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hA2); send_byte(8'h01);
    send_byte(8'h9A); send_byte(8'h01);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hBC);
`endif
    wait_end();
    chk("A_nwrites", nw0 - s0, 32'd3);
    chk("A_addr0", {24'd0, la0[s0[5:0]]}, 32'd0);
    chk("A_data0", {16'd0, ld0[s0[5:0]]}, 32'h0300);
    chk("A_addr1", {24'd0, la0[(s0 + 1) % 64]}, 32'd1);
    chk("A_data1", {16'd0, ld0[(s0 + 1) % 64]}, 32'hA201);
    chk("A_addr2", {24'd0, la0[(s0 + 2) % 64]}, 32'd2);
    chk("A_data2", {16'd0, ld0[(s0 + 2) % 64]}, 32'h9A01);
    chk("A_pulses", pulses0 - p0, 32'd3);
    chk("A_count", {24'd0, wc0}, 32'd3);
    chk("A_done",  {31'd0, done0}, 32'd1);
    chk("A_err",   {31'd0, err0}, 32'd0);
    chk("A_ready_done", {31'd0, rdy0}, 32'd0);
    chk("B254_nwrites", nw1 - s1, 32'd3);
    chk("B254_addr0", {24'd0, la1[s1[5:0]]}, 32'd254);
    chk("B254_addr1", {24'd0, la1[(s1 + 1) % 64]}, 32'd255);
    chk("B254_addr2", {24'd0, la1[(s1 + 2) % 64]}, 32'd0);
    repeat (3) @(negedge Clock);
    chk("A_done_hold", {31'd0, done0}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum
    s0 = nw0;
    start_load();
    chk("B_done_clr", {31'd0, done0}, 32'd0);
    send_byte(8'h03);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hA2); send_byte(8'h01);
    send_byte(8'h9A); send_byte(8'h01);
    send_byte(8'hBD);
    wait_end();
    chk("B_nwrites", nw0 - s0, 32'd3);
    chk("B_err",  {31'd0, err0}, 32'd1);
    chk("B_done", {31'd0, done0}, 32'd0);
`endif

    // Zero-length header
    s0 = nw0;
    start_load();
    send_byte(8'h00);
    wait_end();
    repeat (2) @(negedge Clock);
    chk("C_err", {31'd0, err0}, 32'd1);
    chk("C_done", {31'd0, done0}, 32'd0);
    chk("C_nwrites", nw0 - s0, 32'd0);
    chk("C_count", {24'd0, wc0}, 32'd0);

    // Stall between high and low bytes
    s0 = nw0; p0 = pulses0;
    start_load();
    chk("D_err_clr", {31'd0, err0}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h5A);
    repeat (5) @(negedge Clock);
    chk("D_stall_nowrite", nw0 - s0, 32'd0);
    send_byte(8'hC3);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hE2);
`endif
    wait_end();
    chk("D_nwrites", nw0 - s0, 32'd1);
    chk("D_pulses", pulses0 - p0, 32'd1);
    chk("D_addr", {24'd0, la0[s0[5:0]]}, 32'd0);
    chk("D_data", {16'd0, ld0[s0[5:0]]}, 32'h5AC3);
    chk("D_done", {31'd0, done0}, 32'd1);

    // Reset mid-load after the second word
    s0 = nw0;
    start_load();
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    for (int i = 0; i < 20 && (nw0 - s0) < 2; i++) @(negedge Clock);
    chk("E_two_written", nw0 - s0, 32'd2);
    send_byte(8'h55);
    Reset = 1'b1;
    #1;
    chk("E_rst_ready", {31'd0, rdy0}, 32'd0);
    chk("E_rst_we",    {31'd0, we0}, 32'd0);
    chk("E_rst_addr",  {24'd0, addr0}, 32'd0);
    chk("E_rst_wdata", {16'd0, wd0}, 32'd0);
    chk("E_rst_count", {24'd0, wc0}, 32'd0);
    chk("E_rst_flags", {30'd0, done0, err0}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("E_idle_ready", {31'd0, rdy0}, 32'd0);
    chk("E_no_partial", nw0 - s0, 32'd2);
    s0 = nw0;
    start_load();
    send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hB9);
`endif
    wait_end();
    chk("E_nwrites", nw0 - s0, 32'd1);
    chk("E_addr", {24'd0, la0[s0[5:0]]}, 32'd0);
    chk("E_data", {16'd0, ld0[s0[5:0]]}, 32'h1234);
    chk("E_count", {24'd0, wc0}, 32'd1);
    chk("E_done", {31'd0, done0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
